// File: rtl/uart_rx_core_if.sv
// Write-side bus from the UART receiver to its speculative-write consumer.
// The receiver drives it through the master modport and the consumer listens on slave.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 write_en;
  logic                 commit_write;
  logic                 rollback_write;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    output rx_data, write_en, commit_write, rollback_write,
           parity_err, frame_err, break_det
  );

  modport slave (
    input  rx_data, write_en, commit_write, rollback_write,
           parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver with a speculative write (write_en) that is later
// confirmed (commit_write) or cancelled (rollback_write) once the stop bits are checked.
module uart_rx_core #(
  parameter int DATA_BITS          = 8,
  parameter int PARITY_MODE        = 0,
  parameter int STOP_BITS          = 1,
  parameter int OVERSAMPLE         = 16,
  parameter int ROLLBACK_ON_PARITY = 1
) (
  input  logic           CLK288MHZ,
  input  logic           reset,
  input  logic           uart_rxd_out,
  input  logic           tick,
  output logic           baud_reset,
  output logic           busy,
  uart_rx_core_if.master rxBus
);
  localparam int               CNT_W      = $clog2(OVERSAMPLE);
  localparam int               BIT_W      = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] MID_CNT    = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_MODE != 0);
  localparam bit               PARITY_ODD = (PARITY_MODE == 1);
  localparam bit               ROLL_PAR   = (ROLLBACK_ON_PARITY != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state, nextState;
  logic                 rxMeta, rxS;
  logic [CNT_W-1:0]     tickCnt;
  logic [BIT_W-1:0]     bitCnt;
  logic                 stopCnt;
  logic [DATA_BITS-1:0] shiftReg, shiftNext, rxData;
  logic                 parityBit, parityErrAcc, frameErrAcc;
  logic                 midTick, bitTick;
  logic                 cntClr, cntInc, dataSample, paritySample, stopSample;
  logic                 lastPayload, finalStop;
  logic                 frameNow, breakNow, parityErrNow, rollNow;
  logic                 writeEn, commitWrite, rollbackWrite, parityErr, frameErr, breakDet;

  // The line idles high, so the synchroniser presets to 1 and reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK288MHZ) begin
    if (!reset) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= uart_rxd_out;
      rxS    <= rxMeta;
    end
  end

  assign midTick      = tick && (tickCnt == MID_CNT);
  assign bitTick      = tick && (tickCnt == LAST_CNT);
  assign shiftNext    = {rxS, shiftReg[DATA_BITS-1:1]};
  assign parityErrNow = HAS_PARITY & (^shiftReg ^ rxS ^ PARITY_ODD);
  assign frameNow     = frameErrAcc | ~rxS;
  assign breakNow     = frameNow && (shiftReg == '0) && !parityBit;
  assign rollNow      = frameNow | (parityErrAcc & ROLL_PAR);

  always_ff @(posedge CLK288MHZ) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    nextState    = state;
    cntClr       = 1'b0;
    cntInc       = 1'b0;
    dataSample   = 1'b0;
    paritySample = 1'b0;
    stopSample   = 1'b0;
    lastPayload  = 1'b0;
    finalStop    = 1'b0;
    case (state)
      IDLE: begin
        cntClr = 1'b1;
        if (!rxS) nextState = START;
      end
      START: begin
        if (midTick) begin
          cntClr    = 1'b1;
          nextState = rxS ? IDLE : DATA;
        end else begin
          cntInc = tick;
        end
      end
      DATA: begin
        if (bitTick) begin
          cntClr     = 1'b1;
          dataSample = 1'b1;
          if (bitCnt == LAST_BIT) begin
            lastPayload = !HAS_PARITY;
            nextState   = HAS_PARITY ? PARITY : STOP;
          end
        end else begin
          cntInc = tick;
        end
      end
      PARITY: begin
        if (bitTick) begin
          cntClr       = 1'b1;
          paritySample = 1'b1;
          lastPayload  = 1'b1;
          nextState    = STOP;
        end else begin
          cntInc = tick;
        end
      end
      STOP: begin
        if (bitTick) begin
          cntClr     = 1'b1;
          stopSample = 1'b1;
          if (stopCnt == LAST_STOP) begin
            finalStop = 1'b1;
            nextState = breakNow ? BRK : IDLE;
          end
        end else begin
          cntInc = tick;
        end
      end
      BRK: begin
        if (rxS) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: the datapath is fully reset so outputs are defined low right after reset.
  always_ff @(posedge CLK288MHZ) begin
    if (!reset) begin
      baud_reset    <= 1'b0;
      tickCnt       <= '0;
      bitCnt        <= '0;
      stopCnt       <= 1'b0;
      shiftReg      <= '0;
      rxData        <= '0;
      parityBit     <= 1'b0;
      parityErrAcc  <= 1'b0;
      frameErrAcc   <= 1'b0;
      writeEn       <= 1'b0;
      commitWrite   <= 1'b0;
      rollbackWrite <= 1'b0;
      parityErr     <= 1'b0;
      frameErr      <= 1'b0;
      breakDet      <= 1'b0;
    end else begin
      baud_reset    <= (state == IDLE) && !rxS;
      writeEn       <= lastPayload;
      commitWrite   <= finalStop && !rollNow;
      rollbackWrite <= finalStop && rollNow;
      parityErr     <= finalStop && parityErrAcc;
      frameErr      <= finalStop && frameNow;
      breakDet      <= finalStop && breakNow;

      if (cntClr)      tickCnt <= '0;
      else if (cntInc) tickCnt <= tickCnt + 1'b1;

      if (state == IDLE) begin
        bitCnt       <= '0;
        stopCnt      <= 1'b0;
        parityBit    <= 1'b0;
        parityErrAcc <= 1'b0;
        frameErrAcc  <= 1'b0;
      end
      if (dataSample) begin
        shiftReg <= shiftNext;
        bitCnt   <= bitCnt + 1'b1;
      end
      if (paritySample) begin
        parityBit    <= rxS;
        parityErrAcc <= parityErrNow;
      end
      if (stopSample) begin
        stopCnt     <= stopCnt + 1'b1;
        frameErrAcc <= frameNow;
      end
      // rx_data only moves with write_en, so it holds steady while the next frame shifts in.
      if (lastPayload) rxData <= (state == DATA) ? shiftNext : shiftReg;
    end
  end

  assign busy                 = (state != IDLE);
  assign rxBus.rx_data        = rxData;
  assign rxBus.write_en       = writeEn;
  assign rxBus.commit_write   = commitWrite;
  assign rxBus.rollback_write = rollbackWrite;
  assign rxBus.parity_err     = parityErr;
  assign rxBus.frame_err      = frameErr;
  assign rxBus.break_det      = breakDet;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: four receivers (8N1, 8E1 rollback, 8E1 commit, 8N2)
// share one tick strobe; each has its own serial line.
module tb_uart_rx_core;
  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       tick    = 1'b0;
  logic [1:0] tickDiv = 2'd0;
  logic [3:0] rxd     = 4'hF;
  int         nChecks = 0;
  int         nFail   = 0;

  always #5 clk = ~clk;

  // One tick every 4 clocks: a bit period is 16 ticks = 64 clocks.
  always @(negedge clk) begin
    tickDiv = tickDiv + 2'd1;
    tick    = (tickDiv == 2'd0);
  end

  uart_rx_core_if #(.DATA_BITS(8)) busA (), busE (), busC (), busT ();
  wire [3:0] brV, busyV;

  uart_rx_core #(.PARITY_MODE(0)) dutA (
    .CLK288MHZ(clk), .reset(reset), .uart_rxd_out(rxd[0]), .tick(tick),
    .baud_reset(brV[0]), .busy(busyV[0]), .rxBus(busA));
  uart_rx_core #(.PARITY_MODE(2), .ROLLBACK_ON_PARITY(1)) dutE (
    .CLK288MHZ(clk), .reset(reset), .uart_rxd_out(rxd[1]), .tick(tick),
    .baud_reset(brV[1]), .busy(busyV[1]), .rxBus(busE));
  uart_rx_core #(.PARITY_MODE(2), .ROLLBACK_ON_PARITY(0)) dutC (
    .CLK288MHZ(clk), .reset(reset), .uart_rxd_out(rxd[2]), .tick(tick),
    .baud_reset(brV[2]), .busy(busyV[2]), .rxBus(busC));
  uart_rx_core #(.STOP_BITS(2)) dutT (
    .CLK288MHZ(clk), .reset(reset), .uart_rxd_out(rxd[3]), .tick(tick),
    .baud_reset(brV[3]), .busy(busyV[3]), .rxBus(busT));

  wire [3:0] weV = {busT.write_en, busC.write_en, busE.write_en, busA.write_en};
  wire [3:0] cmV = {busT.commit_write, busC.commit_write, busE.commit_write, busA.commit_write};
  wire [3:0] rbV = {busT.rollback_write, busC.rollback_write, busE.rollback_write, busA.rollback_write};
  wire [3:0] peV = {busT.parity_err, busC.parity_err, busE.parity_err, busA.parity_err};
  wire [3:0] feV = {busT.frame_err, busC.frame_err, busE.frame_err, busA.frame_err};
  wire [3:0] bdV = {busT.break_det, busC.break_det, busE.break_det, busA.break_det};
  wire [7:0] dataV [4];
  assign dataV[0] = busA.rx_data;
  assign dataV[1] = busE.rx_data;
  assign dataV[2] = busC.rx_data;
  assign dataV[3] = busT.rx_data;
  wire [15:0] outsA = {busA.rx_data, busA.write_en, busA.commit_write, busA.rollback_write,
                       busA.parity_err, busA.frame_err, busA.break_det, brV[0], busyV[0]};

  // Pulse monitor: counts strobes and captures data/flags as they appear.
  int         weCnt[4]    = '{default: 0};
  int         cmCnt[4]    = '{default: 0};
  int         rbCnt[4]    = '{default: 0};
  int         brCnt[4]    = '{default: 0};
  int         strayCnt[4] = '{default: 0};
  logic [7:0] lastData[4];
  logic       lastPe[4], lastFe[4], lastBd[4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (weV[i] === 1'b1) begin
        weCnt[i]++;
        lastData[i] = dataV[i];
      end
      if (cmV[i] === 1'b1 || rbV[i] === 1'b1) begin
        lastPe[i] = peV[i];
        lastFe[i] = feV[i];
        lastBd[i] = bdV[i];
        if (cmV[i] === 1'b1) cmCnt[i]++;
        if (rbV[i] === 1'b1) rbCnt[i]++;
        if (cmV[i] === 1'b1 && (rbV[i] === 1'b1 || bdV[i] === 1'b1)) strayCnt[i]++;
      end else if ((peV[i] | feV[i] | bdV[i]) === 1'b1) begin
        strayCnt[i]++;
      end
      if (brV[i] === 1'b1) brCnt[i]++;
    end
  end

  int sWe[4], sCm[4], sRb[4], sBr[4];

  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      sWe[i] = weCnt[i];
      sCm[i] = cmCnt[i];
      sRb[i] = rbCnt[i];
      sBr[i] = brCnt[i];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic holdLine(input logic [3:0] mask, input logic v, input int ticks);
    for (int i = 0; i < 4; i++) if (mask[i]) rxd[i] = v;
    repeat (ticks * 4) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [3:0] mask, input logic [7:0] d, input bit hasPar,
                           input logic pbit, input bit twoStops, input logic stop2,
                           input int lastTicks);
    holdLine(mask, 1'b0, 16);
    for (int i = 0; i < 8; i++) holdLine(mask, d[i], 16);
    if (hasPar) holdLine(mask, pbit, 16);
    if (twoStops) begin
      holdLine(mask, 1'b1, 16);
      holdLine(mask, stop2, lastTicks);
    end else begin
      holdLine(mask, 1'b1, lastTicks);
    end
    holdLine(mask, 1'b1, 32);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("reset_outs_A", 32'(outsA), 32'h0);
    check("reset_busy_all", 32'(busyV), 32'h0);
    check("reset_strobes_all", 32'(weV | cmV | rbV | brV), 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // 8N1 0xA5 -> commit, no flags
    snap();
    sendFrame(4'b0001, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("a5_we_count", 32'(weCnt[0] - sWe[0]), 32'd1);
    check("a5_data", 32'(lastData[0]), 32'hA5);
    check("a5_commit", 32'(cmCnt[0] - sCm[0]), 32'd1);
    check("a5_rollback", 32'(rbCnt[0] - sRb[0]), 32'd0);
    check("a5_flags", 32'({lastPe[0], lastFe[0], lastBd[0]}), 32'h0);
    check("a5_idle", 32'(busyV[0]), 32'h0);

    // Even parity 0x37 with parity bit 0 (five ones -> parity error)
    snap();
    sendFrame(4'b0110, 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 16);
    check("par_we_E", 32'(weCnt[1] - sWe[1]), 32'd1);
    check("par_data_E", 32'(lastData[1]), 32'h37);
    check("par_rollback_E", 32'(rbCnt[1] - sRb[1]), 32'd1);
    check("par_commit_E", 32'(cmCnt[1] - sCm[1]), 32'd0);
    check("par_flags_E", 32'({lastPe[1], lastFe[1]}), 32'h2);
    check("par_commit_C", 32'(cmCnt[2] - sCm[2]), 32'd1);
    check("par_rollback_C", 32'(rbCnt[2] - sRb[2]), 32'd0);
    check("par_flags_C", 32'({lastPe[2], lastFe[2]}), 32'h2);

    // Even parity 0x37 with correct parity bit 1
    snap();
    sendFrame(4'b0010, 8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 16);
    check("pargood_commit_E", 32'(cmCnt[1] - sCm[1]), 32'd1);
    check("pargood_pe_E", 32'(lastPe[1]), 32'h0);

    // 8N2 clean frame, then second stop bit low
    snap();
    sendFrame(4'b1000, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 16);
    check("n2_commit", 32'(cmCnt[3] - sCm[3]), 32'd1);
    check("n2_data", 32'(lastData[3]), 32'hC3);
    snap();
    sendFrame(4'b1000, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 12);
    check("n2bad_we", 32'(weCnt[3] - sWe[3]), 32'd1);
    check("n2bad_rollback", 32'(rbCnt[3] - sRb[3]), 32'd1);
    check("n2bad_commit", 32'(cmCnt[3] - sCm[3]), 32'd0);
    check("n2bad_flags", 32'({lastPe[3], lastFe[3], lastBd[3]}), 32'h2);

    // Low glitch of 4 ticks -> one baud_reset, false start
    snap();
    holdLine(4'b0001, 1'b0, 4);
    holdLine(4'b0001, 1'b1, 32);
    check("glitch_baud_reset", 32'(brCnt[0] - sBr[0]), 32'd1);
    check("glitch_no_we", 32'(weCnt[0] - sWe[0]), 32'd0);
    check("glitch_no_end", 32'((cmCnt[0] - sCm[0]) + (rbCnt[0] - sRb[0])), 32'd0);
    check("glitch_idle", 32'(busyV[0]), 32'h0);

    // Break: line low for 20 bit times
    snap();
    holdLine(4'b0001, 1'b0, 16 * 20);
    check("brk_busy_low", 32'(busyV[0]), 32'h1);
    check("brk_we", 32'(weCnt[0] - sWe[0]), 32'd1);
    check("brk_data", 32'(lastData[0]), 32'h00);
    check("brk_rollback", 32'(rbCnt[0] - sRb[0]), 32'd1);
    check("brk_flags", 32'({lastFe[0], lastBd[0]}), 32'h3);
    holdLine(4'b0001, 1'b1, 8);
    check("brk_idle_after_high", 32'(busyV[0]), 32'h0);
    snap();
    sendFrame(4'b0001, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("postbrk_commit", 32'(cmCnt[0] - sCm[0]), 32'd1);
    check("postbrk_data", 32'(lastData[0]), 32'h3C);

    // Reset in the middle of data bit 3
    snap();
    holdLine(4'b0001, 1'b0, 16);
    holdLine(4'b0001, 1'b0, 16);
    holdLine(4'b0001, 1'b1, 16);
    holdLine(4'b0001, 1'b0, 16);
    holdLine(4'b0001, 1'b1, 8);
    check("rst_busy_before", 32'(busyV[0]), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_outs_next_cycle", 32'(outsA), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    holdLine(4'b0001, 1'b1, 16 * 12);
    check("rst_no_we", 32'(weCnt[0] - sWe[0]), 32'd0);
    check("rst_no_end", 32'((cmCnt[0] - sCm[0]) + (rbCnt[0] - sRb[0])), 32'd0);
    snap();
    sendFrame(4'b0001, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("post_rst_we", 32'(weCnt[0] - sWe[0]), 32'd1);
    check("post_rst_data", 32'(lastData[0]), 32'h5A);
    check("post_rst_commit", 32'(cmCnt[0] - sCm[0]), 32'd1);

    check("stray_flags_all", 32'(strayCnt[0] + strayCnt[1] + strayCnt[2] + strayCnt[3]), 32'd0);

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end
endmodule
